// File: rtl/mlp_requant_act_if.sv
// Handshake/data bundle for mlp_requant_act: the accumulator-side input beat and
// the activation-side output beat, with DUT-side (slave) and driver-side (master) views.
interface mlp_requant_act_if #(
  parameter int ACC_WIDTH  = 64,
  parameter int BIAS_WIDTH = 32,
  parameter int OUT_WIDTH  = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [ACC_WIDTH-1:0]  acc_in;
  logic signed [BIAS_WIDTH-1:0] bias;
  logic                         relu_en;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_sat;

  modport master (
    output in_valid, acc_in, bias, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, acc_in, bias, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mlp_requant_act.sv
// Bias add, round-half-up rescale, ReLU and saturation in a 3-stage stallable pipeline.
// Optional leaky ReLU negative slope is enabled by defining MLP_REQUANT_LEAKY_EN.
module mlp_requant_act #(
  parameter int ACC_WIDTH   = 64,
  parameter int BIAS_WIDTH  = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int FRAC_SHIFT  = 8,
  parameter int LEAKY_SHIFT = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mlp_requant_act_if.slave     bus,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam int SW = ACC_WIDTH + 1;  // bias sum, cannot wrap
  localparam int RW = ACC_WIDTH + 2;  // rounding headroom

  localparam logic signed [RW-1:0] SAT_MAX =
    {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN =
    {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  if (BIAS_WIDTH > ACC_WIDTH || OUT_WIDTH >= ACC_WIDTH || FRAC_SHIFT < 0 ||
      FRAC_SHIFT >= ACC_WIDTH || LEAKY_SHIFT < 0 || LEAKY_SHIFT >= RW) begin : g_bad_params
    $error("mlp_requant_act: illegal parameter combination");
  end

  logic stall;
  logic advance;

  logic                 s1_valid_q;
  logic signed [SW-1:0] s1_sum_q;
  logic signed [SW-1:0] s1_sum_d;
  logic                 s1_relu_q;

  logic                 s2_valid_q;
  logic signed [RW-1:0] s2_r_q;
  logic signed [RW-1:0] s2_r_d;
  logic                 s2_relu_q;

  logic signed [RW-1:0]        act;
  logic signed [OUT_WIDTH-1:0] out_data_d;
  logic                        out_sat_d;

  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic                        out_sat_q;
  logic [CNT_WIDTH-1:0]        sat_count_q;

  // One global stall freezes every stage, so bubbles stay where they are.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign advance      = ~stall;
  assign bus.in_ready = advance;

  assign s1_sum_d = {bus.acc_in[ACC_WIDTH-1], bus.acc_in}
                  + {{(SW-BIAS_WIDTH){bus.bias[BIAS_WIDTH-1]}}, bus.bias};

  // NOTE: sequential state is written with <= so every stage samples the pre-edge
  // value of the stage before it; blocking = here would collapse the pipeline.
  // NOTE: data registers are reset too, so out_data is 0 rather than X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_relu_q  <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum_q  <= s1_sum_d;
        s1_relu_q <= bus.relu_en;
      end
    end
  end

  if (FRAC_SHIFT > 0) begin : g_round
    localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    logic signed [RW-1:0] biased;
    assign biased = {s1_sum_q[SW-1], s1_sum_q} + HALF;
    assign s2_r_d = biased >>> FRAC_SHIFT;
  end else begin : g_no_round
    assign s2_r_d = {s1_sum_q[SW-1], s1_sum_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
      s2_relu_q  <= 1'b0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_r_q    <= s2_r_d;
        s2_relu_q <= s1_relu_q;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    act        = s2_r_q;
    out_sat_d  = 1'b1;
    out_data_d = SAT_MAX[OUT_WIDTH-1:0];
    if (s2_relu_q && s2_r_q[RW-1]) begin
`ifdef MLP_REQUANT_LEAKY_EN
      act = s2_r_q >>> LEAKY_SHIFT;
`else
      act = '0;
`endif
    end
    if (act > SAT_MAX) begin
      out_data_d = SAT_MAX[OUT_WIDTH-1:0];
    end else if (act < SAT_MIN) begin
      out_data_d = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      out_data_d = act[OUT_WIDTH-1:0];
      out_sat_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  // Clear wins over a coincident saturated handshake; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      sat_count_q <= '0;
    end else if (out_valid_q && bus.out_ready && out_sat_q && !(&sat_count_q)) begin
      sat_count_q <= sat_count_q + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_count     = sat_count_q;

endmodule
